issue_unit: RTL and testbench

ISSUE_UNIT -- requirements
Module: issue_unit

---
 rtl/issue_unit.sv | 153 +++++++++++++++
 tb/tb_issue_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
// issue_unit
// Credit-based in-order dispatch from a multi-way decode group into a set of
// reservation stations. A reorder buffer also has to have room for each
// instruction. Each station and the ROB has a free-entry counter. A way
// issues only if every lower valid way issued and credit is left after the
// lower ways of the same cycle take theirs. Refused ways are not buffered:
// upstream must present them again.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   flush          synchronous flush: drops the group, refills all credits
//   single_issue   at most the lowest valid way may issue
//   in_valid       per-way valid (0 = bubble)
//   in_station     per-way target station, packed lane-major
//   in_payload     per-way opaque payload, packed lane-major
//   st_release     per-station one-entry-freed pulse
//   rob_release    number of ROB entries retired this cycle
//   accepted       per-way accept (combinational)
//   stop           some valid way refused (combinational)
//   out_valid      registered issued valid, same lane as the input
//   out_station    registered station index
//   out_payload    registered payload
//   credit_err     sticky: a release overflowed a counter
module issue_unit #(
  parameter int XLEN      = 32,
  parameter int WAYS      = 2,
  parameter int NUM_ST    = 3,
  parameter int ST_DEPTH  = 4,
  parameter int ROB_DEPTH = 8,
  parameter int PW        = 2*XLEN+64,
  localparam int SW  = (NUM_ST > 1) ? $clog2(NUM_ST) : 1,
  localparam int RRW = $clog2(WAYS+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 single_issue,
  input  logic [WAYS-1:0]      in_valid,
  input  logic [WAYS*SW-1:0]   in_station,
  input  logic [WAYS*PW-1:0]   in_payload,
  input  logic [NUM_ST-1:0]    st_release,
  input  logic [RRW-1:0]       rob_release,
  output logic [WAYS-1:0]      accepted,
  output logic                 stop,
  output logic [WAYS-1:0]      out_valid,
  output logic [WAYS*SW-1:0]   out_station,
  output logic [WAYS*PW-1:0]   out_payload,
  output logic                 credit_err
);

  localparam int SCW = $clog2(ST_DEPTH+1);
  localparam int RCW = $clog2(ROB_DEPTH+1);

  logic [SCW-1:0] st_cnt  [NUM_ST];
  logic [SCW-1:0] st_take [NUM_ST];
  logic [SCW-1:0] st_nxt  [NUM_ST];
  logic [SCW:0]   st_sum  [NUM_ST];
  logic [RCW-1:0] rob_cnt;
  logic [RCW-1:0] rob_take;
  logic [RCW-1:0] rob_nxt;
  logic [RCW:0]   rob_sum;
  logic           ovf;

  logic           blocked;
  logic           seen_valid;
  logic           st_ok;
  logic [SW-1:0]  sel;

  // Walk the ways from lowest to highest. st_take and rob_take count what
  // the lower ways already took this cycle. The first refused valid way
  // sets blocked, which keeps the issue in order. Bubbles do not touch
  // blocked or the counts.
  always_comb begin
    accepted   = '0;
    blocked    = 1'b0;
    seen_valid = 1'b0;
    rob_take   = '0;
    st_ok      = 1'b0;
    sel        = '0;
    for (int s = 0; s < NUM_ST; s++) st_take[s] = '0;
    for (int w = 0; w < WAYS; w++) begin
      sel   = in_station[w*SW +: SW];
      st_ok = 1'b0;
      for (int s = 0; s < NUM_ST; s++)
        if (sel == SW'(s) && st_cnt[s] > st_take[s]) st_ok = 1'b1;
      if (in_valid[w]) begin
        if (!reset && !flush && !blocked && !(single_issue && seen_valid) &&
            st_ok && rob_cnt > rob_take) begin
          accepted[w] = 1'b1;
          rob_take    = rob_take + RCW'(1);
          for (int s = 0; s < NUM_ST; s++)
            if (sel == SW'(s)) st_take[s] = st_take[s] + SCW'(1);
        end else begin
          blocked = 1'b1;
        end
        seen_valid = 1'b1;
      end
    end
    stop = !reset && !flush && |(in_valid & ~accepted);
  end

  // Next counter values: current - issued + released, saturating at depth.
  // The issued count never exceeds the current value, so the subtraction
  // cannot wrap.
  always_comb begin
    ovf = 1'b0;
    for (int s = 0; s < NUM_ST; s++) begin
      st_sum[s] = {1'b0, st_cnt[s]} - {1'b0, st_take[s]} + (SCW+1)'(st_release[s]);
      if (st_sum[s] > (SCW+1)'(ST_DEPTH)) begin
        st_nxt[s] = SCW'(ST_DEPTH);
        ovf       = 1'b1;
      end else begin
        st_nxt[s] = st_sum[s][SCW-1:0];
      end
    end
    rob_sum = {1'b0, rob_cnt} - {1'b0, rob_take} + (RCW+1)'(rob_release);
    if (rob_sum > (RCW+1)'(ROB_DEPTH)) begin
      rob_nxt = RCW'(ROB_DEPTH);
      ovf     = 1'b1;
    end else begin
      rob_nxt = rob_sum[RCW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_ST; s++) st_cnt[s] <= SCW'(ST_DEPTH);
      rob_cnt     <= RCW'(ROB_DEPTH);
      out_valid   <= '0;
      out_station <= '0;
      out_payload <= '0;
      credit_err  <= 1'b0;
    end else if (flush) begin
      // Any release that arrives with a flush is ignored. The refill already
      // covers it.
      for (int s = 0; s < NUM_ST; s++) st_cnt[s] <= SCW'(ST_DEPTH);
      rob_cnt   <= RCW'(ROB_DEPTH);
      out_valid <= '0;
    end else begin
      for (int s = 0; s < NUM_ST; s++) st_cnt[s] <= st_nxt[s];
      rob_cnt   <= rob_nxt;
      out_valid <= accepted;
      for (int w = 0; w < WAYS; w++) begin
        if (accepted[w]) begin
          out_station[w*SW +: SW] <= in_station[w*SW +: SW];
          out_payload[w*PW +: PW] <= in_payload[w*PW +: PW];
        end
      end
      if (ovf) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit
// Scoreboard bench for issue_unit with default parameters (2 ways, 3
// stations of 4 entries, 8-entry ROB, 128-bit payload). Each step drives one
// decode group and checks accepted/stop against hand-derived constants. It
// pushes the expected registered output, then pops it and compares after the
// next clock edge.
module tb_issue_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         single_issue;
  logic [1:0]   in_valid;
  logic [3:0]   in_station;
  logic [255:0] in_payload;
  logic [2:0]   st_release;
  logic [1:0]   rob_release;
  logic [1:0]   accepted;
  logic         stop;
  logic [1:0]   out_valid;
  logic [3:0]   out_station;
  logic [255:0] out_payload;
  logic         credit_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]   v;
    logic [3:0]   st;
    logic [255:0] pl;
  } exp_t;

  exp_t sb [$];

  issue_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .single_issue(single_issue),
    .in_valid(in_valid), .in_station(in_station), .in_payload(in_payload),
    .st_release(st_release), .rob_release(rob_release),
    .accepted(accepted), .stop(stop), .out_valid(out_valid),
    .out_station(out_station), .out_payload(out_payload),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge. accepted/stop are checked
  // mid-cycle. Registered outputs are checked 1 time unit after the next edge.
  task automatic step(input string tag, input logic fl, input logic si,
                      input logic [1:0] v, input logic [1:0] s0, input logic [1:0] s1,
                      input logic [2:0] srel, input logic [1:0] rrel,
                      input logic [1:0] ea, input logic es);
    exp_t e;
    exp_t g;
    logic [127:0] p0;
    logic [127:0] p1;
    p0 = {$urandom, $urandom, $urandom, $urandom};
    p1 = {$urandom, $urandom, $urandom, $urandom};
    flush        = fl;
    single_issue = si;
    in_valid     = v;
    in_station   = {s1, s0};
    in_payload   = {p1, p0};
    st_release   = srel;
    rob_release  = rrel;
    #3;
    chk({tag, ":accepted"}, 128'(accepted), 128'(ea));
    chk({tag, ":stop"}, 128'(stop), 128'(es));
    e.v  = ea;
    e.st = {s1, s0};
    e.pl = {p1, p0};
    sb.push_back(e);
    @(posedge clk);
    #1;
    flush = 1'b0; single_issue = 1'b0; in_valid = '0;
    st_release = '0; rob_release = '0;
    if (sb.size() == 0) begin
      chk({tag, ":sb_empty"}, 128'(1), 128'(0));
    end else begin
      g = sb.pop_front();
      chk({tag, ":out_valid"}, 128'(out_valid), 128'(g.v));
      for (int i = 0; i < 2; i++) begin
        if (g.v[i]) begin
          chk({tag, ":out_station"}, 128'(out_station[i*2 +: 2]), 128'(g.st[i*2 +: 2]));
          chk({tag, ":out_payload"}, out_payload[i*128 +: 128], g.pl[i*128 +: 128]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; single_issue = 1'b0;
    in_valid = 2'b11; in_station = 4'b0100; in_payload = '1;
    st_release = '0; rob_release = '0;
    #3;
    chk("rst:accepted",   128'(accepted),   128'(0));
    chk("rst:stop",       128'(stop),       128'(0));
    chk("rst:out_valid",  128'(out_valid),  128'(0));
    chk("rst:out_pl",     out_payload[127:0], 128'(0));
    chk("rst:credit_err", 128'(credit_err), 128'(0));
    in_valid = '0;
    #9 reset = 1'b0;
    @(posedge clk); #1;

    //   tag        fl    si    v      s0     s1     srel    rrel   acc    stop   (st0,st1,st2;rob after)
    step("defaults", 1'b0, 1'b0, 2'b11, 2'd0, 2'd1, 3'b000, 2'd0, 2'b11, 1'b0); // 3,3,4;6
    step("fill_st2", 1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 3'b000, 2'd0, 2'b11, 1'b0); // 3,3,2;4
    step("one_st2",  1'b0, 1'b0, 2'b01, 2'd2, 2'd0, 3'b000, 2'd0, 2'b01, 1'b0); // 3,3,1;3
    step("st2_cr1",  1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 3'b100, 2'd0, 2'b01, 1'b1); // st2 1;2
    step("represent",1'b0, 1'b0, 2'b10, 2'd0, 2'd2, 3'b000, 2'd0, 2'b10, 1'b0); // st2 0;1
    step("rel_late", 1'b0, 1'b0, 2'b01, 2'd2, 2'd0, 3'b100, 2'd0, 2'b00, 1'b1); // st2 1;1
    step("rel_used", 1'b0, 1'b0, 2'b01, 2'd2, 2'd0, 3'b000, 2'd0, 2'b01, 1'b0); // st2 0;0
    step("rob_zero", 1'b0, 1'b0, 2'b01, 2'd0, 2'd0, 3'b000, 2'd2, 2'b00, 1'b1); // rob 2
    step("rob_back", 1'b0, 1'b0, 2'b01, 2'd0, 2'd0, 3'b000, 2'd0, 2'b01, 1'b0); // st0 2;1
    step("single",   1'b0, 1'b1, 2'b11, 2'd0, 2'd1, 3'b000, 2'd2, 2'b01, 1'b1); // st0 1;2
    step("rob_two",  1'b0, 1'b0, 2'b11, 2'd1, 2'd1, 3'b000, 2'd0, 2'b11, 1'b0); // st1 1;0
    step("flush",    1'b1, 1'b0, 2'b11, 2'd0, 2'd1, 3'b111, 2'd1, 2'b00, 1'b0); // 4,4,4;8
    step("post_fl1", 1'b0, 1'b0, 2'b11, 2'd0, 2'd0, 3'b000, 2'd0, 2'b11, 1'b0); // st0 2;6
    step("post_fl2", 1'b0, 1'b0, 2'b11, 2'd0, 2'd0, 3'b000, 2'd0, 2'b11, 1'b0); // st0 0;4
    step("st0_zero", 1'b0, 1'b0, 2'b01, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00, 1'b1);
    chk("err_clear", 128'(credit_err), 128'(0));
    step("over_rel", 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 3'b100, 2'd0, 2'b00, 1'b0); // st2 stays 4
    chk("err_set", 128'(credit_err), 128'(1));
    step("sat_a",    1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 3'b000, 2'd2, 2'b11, 1'b0); // st2 2;4
    step("sat_b",    1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 3'b000, 2'd2, 2'b11, 1'b0); // st2 0;4
    step("sat_c",    1'b0, 1'b0, 2'b01, 2'd2, 2'd0, 3'b000, 2'd0, 2'b00, 1'b1);
    step("flush2",   1'b1, 1'b0, 2'b00, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00, 1'b0);
    chk("err_sticky", 128'(credit_err), 128'(1));
    step("pre_rst",  1'b0, 1'b0, 2'b11, 2'd0, 2'd1, 3'b000, 2'd0, 2'b11, 1'b0);

    // Reset arrives in the middle of an issue cycle. The group in flight is
    // dropped and the outputs clear without waiting for a clock edge.
    in_valid = 2'b11; in_station = 4'b0100; in_payload = '1;
    #2;
    chk("mid:acc_before", 128'(accepted), 128'(3));
    reset = 1'b1;
    #1;
    chk("mid:accepted",   128'(accepted),   128'(0));
    chk("mid:stop",       128'(stop),       128'(0));
    chk("mid:out_valid",  128'(out_valid),  128'(0));
    chk("mid:out_pl",     out_payload[255:128], 128'(0));
    chk("mid:credit_err", 128'(credit_err), 128'(0));
    in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    step("post_rst", 1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 3'b000, 2'd0, 2'b11, 1'b0);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
